// File: rtl/rr_mux_pkg.sv
// Shared helpers for the round-robin stream merger.
package rr_mux_pkg;

  // Increments v and wraps at n rather than at the next power of two.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/dti.sv
// Valid/ready stream interface: the producer drives data and valid, the consumer drives ready.
interface dti #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. It scans the requests upward from ptr, wraps modulo SIZE,
// and grants the first active request it finds.
module rr_arbiter #(
  parameter int SIZE  = 2,
  parameter int IDX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [SIZE-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int unsigned idx;

  always_comb begin
    // NOTE: every output gets a default first, so no path through the block leaves a latch.
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < SIZE; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= SIZE) idx = idx - SIZE;
      if (!any && req[IDX_W'(idx)]) begin
        any                 = 1'b1;
        gnt[IDX_W'(idx)]    = 1'b1;
        gnt_idx             = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// Merges SIZE input streams into one registered output stream. Each output word carries
// the index of its source input in the top IDX_W bits.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int DIN_W = 16
) (
  input  logic  clk,
  input  logic  rst,
  dti.consumer  din [SIZE-1:0],
  dti.producer  dout
);

  localparam int IDX_W = $clog2(SIZE);
  localparam int OUT_W = IDX_W + DIN_W;

  logic [SIZE-1:0]  req;
  logic [SIZE-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             any;
  logic             load;
  logic [DIN_W-1:0] in_data [SIZE];

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic [IDX_W-1:0] ptr_q,       ptr_d;

  for (genvar i = 0; i < SIZE; i++) begin : g_in
    assign req[i]       = din[i].valid;
    assign in_data[i]   = din[i].data;
    assign din[i].ready = load & gnt[i] & any;
  end

  rr_arbiter #(.SIZE(SIZE), .IDX_W(IDX_W)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Gating load with rst keeps every input's ready low while reset is held.
  assign load       = rst & (~out_valid_q | dout.ready);
  assign dout.valid = out_valid_q;
  assign dout.data  = out_data_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (any) begin
        out_valid_d = 1'b1;
        out_data_d  = {gnt_idx, in_data[gnt_idx]};
        ptr_d       = IDX_W'(wrap_inc(32'(gnt_idx), SIZE));
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers take non-blocking assignments, so every flop samples its pre-edge inputs.
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Randomised scoreboard bench for rr_mux. It drives a SIZE=4 instance and a SIZE=3 instance
// side by side and checks both against a round-robin reference model.
module tb_rr_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dready [2];
  logic        vld    [2][4];
  logic [15:0] dat    [2][4];
  logic        acc    [2][4];
  wire         rdy    [2][4];
  wire         ov     [2];
  wire  [17:0] od     [2];

  dti #(.W(16)) a_in [3:0] ();
  dti #(.W(16)) b_in [2:0] ();
  dti #(.W(18)) a_out ();
  dti #(.W(18)) b_out ();

  for (genvar i = 0; i < 4; i++) begin : g_a
    assign a_in[i].valid = vld[0][i];
    assign a_in[i].data  = dat[0][i];
    assign rdy[0][i]     = a_in[i].ready;
  end
  for (genvar i = 0; i < 3; i++) begin : g_b
    assign b_in[i].valid = vld[1][i];
    assign b_in[i].data  = dat[1][i];
    assign rdy[1][i]     = b_in[i].ready;
  end
  assign rdy[1][3]   = 1'b0;
  assign a_out.ready = dready[0];
  assign b_out.ready = dready[1];
  assign ov[0] = a_out.valid;
  assign od[0] = a_out.data;
  assign ov[1] = b_out.valid;
  assign od[1] = b_out.data;

  rr_mux #(.SIZE(4), .DIN_W(16)) dut_a (.clk(clk), .rst(rst), .din(a_in), .dout(a_out));
  rr_mux #(.SIZE(3), .DIN_W(16)) dut_b (.clk(clk), .rst(rst), .din(b_in), .dout(b_out));

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s unit%0d at %0t: got %h expected %h", name, u, $time, act, exp);
    end
  endtask

  // Reference model: the next grant, the pending output and the expected output sequence.
  int          ptr_m [2] = '{0, 0};
  bit          ov_m  [2] = '{0, 0};
  logic [17:0] q0 [$];
  logic [17:0] q1 [$];

  function automatic int nsz(input int u);
    return (u == 0) ? 4 : 3;
  endfunction

  function automatic int grant(input int u);
    for (int k = 0; k < nsz(u); k++) begin
      int i;
      i = (ptr_m[u] + k) % nsz(u);
      if (vld[u][i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int g;
      logic [1:0] gi;
      if (!rst) begin
        ov_m[u]  = 1'b0;
        ptr_m[u] = 0;
        if (u == 0) q0.delete(); else q1.delete();
      end else if (!ov_m[u] || dready[u]) begin
        g = grant(u);
        if (g >= 0) begin
          gi = 2'(g);
          if (u == 0) q0.push_back({gi, dat[u][g]}); else q1.push_back({gi, dat[u][g]});
          ov_m[u]  = 1'b1;
          ptr_m[u] = (g + 1) % nsz(u);
        end else begin
          ov_m[u] = 1'b0;
        end
      end
    end
  end

  // Monitor: compares ready, valid and the data of each output handshake.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic [3:0]  act_r, exp_r;
      logic [17:0] exp_d;
      bit          ld;
      int          g;
      ld = rst && (!ov_m[u] || dready[u]);
      g  = grant(u);
      act_r = '0;
      exp_r = '0;
      for (int i = 0; i < 4; i++) begin
        act_r[i]  = rdy[u][i];
        exp_r[i]  = ld && (g == i);
        acc[u][i] = vld[u][i] && rdy[u][i];
      end
      check("din_ready", u, 32'(act_r), 32'(exp_r));
      check("dout_valid", u, 32'(ov[u]), 32'(ov_m[u]));
      if (ov[u] === 1'b1 && dready[u]) begin
        hs_count++;
        if ((u == 0 ? q0.size() : q1.size()) == 0) begin
          check("dout_unexpected", u, 32'(od[u]), 32'hFFFF_FFFF);
        end else begin
          exp_d = (u == 0) ? q0.pop_front() : q1.pop_front();
          check("dout_data", u, 32'(od[u]), 32'(exp_d));
        end
      end
    end
  end

  // One stimulus phase. Each source holds valid and data until it is accepted.
  task automatic run(input int cycles, input int vpct, input logic [3:0] mask,
                     input int rpct, input logic rst_v, input int fixd);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      rst = rst_v;
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < nsz(u); i++) begin
          if (!(vld[u][i] && !acc[u][i])) begin
            vld[u][i] = mask[i] && (($urandom % 100) < vpct);
            if (vld[u][i]) dat[u][i] = (fixd >= 0) ? 16'(fixd) : 16'($urandom);
          end
        end
        dready[u] = ($urandom % 100) < rpct;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      dready[u] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        vld[u][i] = 1'b0;
        dat[u][i] = '0;
        acc[u][i] = 1'b0;
      end
    end
    run(3, 100, 4'hF, 100, 1'b0, -1);        // reset with every input valid
    run(12, 100, 4'hF, 100, 1'b1, -1);       // full contention from ptr=0
    run(5, 0, 4'hF, 100, 1'b1, -1);          // drain
    run(6, 100, 4'b0100, 100, 1'b1, 16'h00AB); // single source
    run(5, 0, 4'hF, 100, 1'b1, -1);
    run(2, 100, 4'hF, 100, 1'b1, 16'h1234);
    run(5, 100, 4'hF, 0, 1'b1, 16'h1234);    // backpressure
    run(6, 100, 4'hF, 100, 1'b1, -1);
    run(10, 100, 4'b0110, 100, 1'b1, -1);    // wrap with input 0 idle
    run(2, 100, 4'hF, 0, 1'b1, -1);
    run(1, 100, 4'hF, 0, 1'b0, -1);          // reset while output is stalled
    run(8, 100, 4'hF, 100, 1'b1, -1);
    for (int r = 0; r < 5; r++) begin
      run(120, 55, 4'hF, 65, 1'b1, -1);
      run(1, 55, 4'hF, 65, 1'b0, -1);
    end
    run(20, 0, 4'hF, 100, 1'b1, -1);
    @(negedge clk);
    @(negedge clk);
    check("handshakes_seen", 0, 32'(hs_count >= 200), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
